bbox_extract: RTL

- Video-in analysis block: scans one RGB stream per frame and classifies each active pixel against a runtime key colour.
- Accumulates the bounding box of all matching pixels over the frame.
- At frame end, publishes the box as start/end coordinates in the packed format the box-overlay stage consumes.
- Sits upstream of the overlay, fed by the same camera/HDMI pixel stream.

---
 rtl/bbox_extract_if.sv | 33 +++
 rtl/bbox_extract.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bbox_extract_if.sv
// Pixel stream in / published bounding box out for bbox_extract.
// master drives the video and reads the box; slave is the extractor side.
interface bbox_extract_if #(
    parameter int unsigned H_ACT = 1280,
    parameter int unsigned V_ACT = 720
);
    localparam int unsigned XW = $clog2(H_ACT);
    localparam int unsigned YW = $clog2(V_ACT);
    localparam int unsigned CW = $clog2(H_ACT * V_ACT + 1);

    logic          i_vsync;
    logic          i_de;
    logic [7:0]    i_r;
    logic [7:0]    i_g;
    logic [7:0]    i_b;
    logic [XW-1:0] start_x;
    logic [YW-1:0] start_y;
    logic [XW-1:0] end_x;
    logic [YW-1:0] end_y;
    logic          box_valid;
    logic          frame_done;
    logic [CW-1:0] pix_count;

    modport master (
        output i_vsync, i_de, i_r, i_g, i_b,
        input  start_x, start_y, end_x, end_y, box_valid, frame_done, pix_count
    );

    modport slave (
        input  i_vsync, i_de, i_r, i_g, i_b,
        output start_x, start_y, end_x, end_y, box_valid, frame_done, pix_count
    );
endinterface

// File: rtl/bbox_extract.sv
// Per-frame bounding box of pixels matching a key colour, published at each vsync.
// Define BBOX_HOLD_EN to hold the last valid box for HOLD_FRAMES lost-target frames.
module bbox_extract #(
    parameter int unsigned H_ACT       = 1280,
    parameter int unsigned V_ACT       = 720,
    parameter int unsigned MIN_PIX     = 16,
    parameter int unsigned HOLD_FRAMES = 4
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [23:0]    key_rgb,
    input  logic [7:0]     tol,
    bbox_extract_if.slave  vid
);
    localparam int unsigned XW = $clog2(H_ACT);
    localparam int unsigned YW = $clog2(V_ACT);
    localparam int unsigned CW = $clog2(H_ACT * V_ACT + 1);
    localparam logic [XW-1:0] X_MAX = XW'(H_ACT - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_ACT - 1);

    typedef enum logic [1:0] {WAIT_SOF, ACCUM, PUBLISH} state_e;

    state_e        state_q, state_d;
    logic          vs_q, vs_prev_q, de_q, act_prev_q;
    logic [23:0]   rgb_q, key_q;
    logic [7:0]    tol_q;
    logic [XW-1:0] x_q, mx_q, min_x_q, max_x_q, start_x_q, end_x_q;
    logic [YW-1:0] y_q, my_q, min_y_q, max_y_q, start_y_q, end_y_q;
    logic [CW-1:0] cnt_q, pix_count_q;
    logic          match_q, box_valid_q, frame_done_q;
    logic          vs_rise_c, pix_act_c, line_end_c, match_c, box_ok_c;
    logic          publish_c, acc_en_c, latch_c;
    logic [8:0]    dr_c, dg_c, db_c;

`ifdef BBOX_HOLD_EN
    localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);
    logic [HW-1:0] hold_q;
`else
    logic unused_hold_c;
    assign unused_hold_c = (HOLD_FRAMES != 0);
`endif

    function automatic logic [8:0] absdiff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    endfunction

    // Consumer reads a 0 coordinate as "no box", so a valid box never reports 0.
    function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] v);
        return (v == '0) ? XW'(1) : v;
    endfunction

    function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] v);
        return (v == '0) ? YW'(1) : v;
    endfunction

    // Input register; pixels seen while vsync is high are not active.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vs_q       <= 1'b0;
            vs_prev_q  <= 1'b0;
            de_q       <= 1'b0;
            act_prev_q <= 1'b0;
            rgb_q      <= '0;
        end else begin
            vs_q       <= vid.i_vsync;
            vs_prev_q  <= vs_q;
            de_q       <= vid.i_de;
            act_prev_q <= pix_act_c;
            rgb_q      <= {vid.i_r, vid.i_g, vid.i_b};
        end
    end

    assign vs_rise_c  = vs_q & ~vs_prev_q;
    assign pix_act_c  = de_q & ~vs_q;
    assign line_end_c = act_prev_q & ~pix_act_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_q <= '0;
            y_q <= '0;
        end else if (vs_rise_c) begin
            x_q <= '0;
            y_q <= '0;
        end else if (line_end_c) begin
            x_q <= '0;
            if (y_q != Y_MAX) y_q <= y_q + YW'(1);
        end else if (pix_act_c && (x_q != X_MAX)) begin
            x_q <= x_q + XW'(1);
        end
    end

    assign dr_c    = absdiff(rgb_q[23:16], key_q[23:16]);
    assign dg_c    = absdiff(rgb_q[15:8],  key_q[15:8]);
    assign db_c    = absdiff(rgb_q[7:0],   key_q[7:0]);
    assign match_c = pix_act_c && (state_q != WAIT_SOF) &&
                     (dr_c <= {1'b0, tol_q}) && (dg_c <= {1'b0, tol_q}) &&
                     (db_c <= {1'b0, tol_q});

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            match_q <= 1'b0;
            mx_q    <= '0;
            my_q    <= '0;
        end else begin
            match_q <= match_c;
            mx_q    <= x_q;
            my_q    <= y_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= WAIT_SOF;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_SOF: if (vs_rise_c) state_d = ACCUM;
            ACCUM:    if (vs_rise_c) state_d = PUBLISH;
            PUBLISH:  state_d = ACCUM;
            default:  state_d = WAIT_SOF;
        endcase
    end

    always_comb begin
        publish_c = 1'b0;
        acc_en_c  = 1'b0;
        latch_c   = 1'b0;
        case (state_q)
            WAIT_SOF: latch_c = vs_rise_c;
            ACCUM:    acc_en_c = match_q;
            PUBLISH: begin
                publish_c = 1'b1;
                latch_c   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_q <= '0;
            tol_q <= '0;
        end else if (latch_c) begin
            key_q <= key_rgb;
            tol_q <= tol;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn || publish_c) begin
            min_x_q <= '1;
            max_x_q <= '0;
            min_y_q <= '1;
            max_y_q <= '0;
            cnt_q   <= '0;
        end else if (acc_en_c) begin
            if (mx_q < min_x_q) min_x_q <= mx_q;
            if (mx_q > max_x_q) max_x_q <= mx_q;
            if (my_q < min_y_q) min_y_q <= my_q;
            if (my_q > max_y_q) max_y_q <= my_q;
            if (cnt_q != '1)    cnt_q   <= cnt_q + CW'(1);
        end
    end

    assign box_ok_c = (cnt_q >= CW'(MIN_PIX));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start_x_q    <= '0;
            start_y_q    <= '0;
            end_x_q      <= '0;
            end_y_q      <= '0;
            box_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pix_count_q  <= '0;
`ifdef BBOX_HOLD_EN
            hold_q       <= '0;
`endif
        end else begin
            frame_done_q <= publish_c;
            if (publish_c) begin
                pix_count_q <= cnt_q;
                if (box_ok_c) begin
                    start_x_q   <= clamp_x(min_x_q);
                    start_y_q   <= clamp_y(min_y_q);
                    end_x_q     <= clamp_x(max_x_q);
                    end_y_q     <= clamp_y(max_y_q);
                    box_valid_q <= 1'b1;
`ifdef BBOX_HOLD_EN
                    hold_q      <= HW'(HOLD_FRAMES);
                end else if (hold_q != '0) begin
                    hold_q      <= hold_q - HW'(1);
                    box_valid_q <= 1'b1;
`endif
                end else begin
                    start_x_q   <= '0;
                    start_y_q   <= '0;
                    end_x_q     <= '0;
                    end_y_q     <= '0;
                    box_valid_q <= 1'b0;
                end
            end
        end
    end

    assign vid.start_x    = start_x_q;
    assign vid.start_y    = start_y_q;
    assign vid.end_x      = end_x_q;
    assign vid.end_y      = end_y_q;
    assign vid.box_valid  = box_valid_q;
    assign vid.frame_done = frame_done_q;
    assign vid.pix_count  = pix_count_q;
endmodule
